// File: rtl/array_reduce_pkg.sv
// Purpose : shared types and helpers for the array stream reducer.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
// Contents: red_op_e operator codes, red_state_e FSM states, op_sel decode,
//           identity element per operator.
package array_reduce_pkg;

    // Identity values are produced at this width and narrowed by the caller,
    // so the reducer supports result widths up to RED_MAX_W bits.
    localparam int RED_MAX_W = 64;

    typedef enum logic [2:0] {
        RED_SUM     = 3'd0,
        RED_PRODUCT = 3'd1,
        RED_AND     = 3'd2,
        RED_OR      = 3'd3,
        RED_XOR     = 3'd4
    } red_op_e;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_HOLD   = 2'd2
    } red_state_e;

    // Reserved encodings 5-7 fold as SUM.
    function automatic red_op_e red_decode(input logic [2:0] sel);
        case (sel)
            3'd1:    return RED_PRODUCT;
            3'd2:    return RED_AND;
            3'd3:    return RED_OR;
            3'd4:    return RED_XOR;
            default: return RED_SUM;
        endcase
    endfunction

    // All-ones for AND stays all-ones after narrowing to any result width.
    function automatic logic [RED_MAX_W-1:0] red_identity(input red_op_e op);
        case (op)
            RED_PRODUCT: return {{(RED_MAX_W-1){1'b0}}, 1'b1};
            RED_AND:     return {RED_MAX_W{1'b1}};
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/reduce_alu.sv
// Purpose : one fold step, acc OP elem, all arithmetic modulo 2^RW.
// Latency : combinational.
// Backpr. : none (pure function of its inputs).
// Ports   : op - operator; acc - running accumulator; elem - extended element;
//           result - next accumulator value.
module reduce_alu
    import array_reduce_pkg::*;
#(
    parameter int RW = 32
) (
    input  red_op_e         op,
    input  logic [RW-1:0]   acc,
    input  logic [RW-1:0]   elem,
    output logic [RW-1:0]   result
);

    // Assigning to an RW-wide result keeps only the low RW bits, so SUM and
    // PRODUCT wrap silently without saturation.
    always_comb begin
        result = acc + elem;
        case (op)
            RED_PRODUCT: result = acc * elem;
            RED_AND:     result = acc & elem;
            RED_OR:      result = acc | elem;
            RED_XOR:     result = acc ^ elem;
            default:     result = acc + elem;
        endcase
    end

endmodule

// File: rtl/array_stream_reducer.sv
// Purpose : buffers a frame of up to DEPTH elements, then folds it with the
//           operator sampled on the closing beat and returns one result.
// Latency : closing beat accepted in cycle T -> res_valid high in cycle T+count+2.
// Backpr. : in_ready is low from frame close until the result handshake;
//           res_* hold steady while res_valid && !res_ready.
// Ports   : in_valid/in_ready/in_data/in_keep/in_last/op_sel - element stream;
//           res_valid/res_ready/res_data/res_count/res_overflow - frame result.
module array_stream_reducer
    import array_reduce_pkg::*;
#(
    parameter int DW     = 8,
    parameter int RW     = 32,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    input  logic                         in_keep,
    input  logic                         in_last,
    input  logic [2:0]                   op_sel,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [RW-1:0]                res_data,
    output logic [$clog2(DEPTH+1)-1:0]   res_count,
    output logic                         res_overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    red_state_e     state, state_nxt;
    red_op_e        op_q, op_dec;
    logic [CW-1:0]  count, idx;
    logic           overflow;
    logic [RW-1:0]  acc, alu_out, elem_ext, elem_rd, ident;
    logic [RW-1:0]  buf_mem [DEPTH];
    logic           accept, store;

    assign op_dec = red_decode(op_sel);
    assign ident  = RW'(red_identity(op_dec));

    generate
        if (SIGNED != 0) begin : g_sext
            assign elem_ext = RW'($signed(in_data));
        end else begin : g_zext
            assign elem_ext = RW'(in_data);
        end
    endgenerate

    // Only slots below count are ever read, so the buffer needs no reset.
    // count < DEPTH whenever store is set, so the narrowed index is exact.
    assign store = accept && in_keep && (count < DEPTH_C);

    always_ff @(posedge clk) begin
        if (store) begin
            buf_mem[count[IW-1:0]] <= elem_ext;
        end
    end

    // idx may equal count (== DEPTH) on the final REDUCE cycle; the read is
    // then unused, so the wrapped index is harmless.
    assign elem_rd = buf_mem[idx[IW-1:0]];

    reduce_alu #(
        .RW (RW)
    ) u_alu (
        .op     (op_q),
        .acc    (acc),
        .elem   (elem_rd),
        .result (alu_out)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = (state == ST_FILL);
        accept    = in_valid && (state == ST_FILL);
        case (state)
            ST_FILL:   if (accept && in_last) state_nxt = ST_REDUCE;
            ST_REDUCE: if (idx == count)      state_nxt = ST_HOLD;
            ST_HOLD:   if (res_ready)         state_nxt = ST_FILL;
            default:                          state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            overflow     <= 1'b0;
            op_q         <= RED_SUM;
            acc          <= '0;
            idx          <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_count    <= '0;
            res_overflow <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        // The closing beat's own element obeys the same
                        // store-or-drop rule as every other beat.
                        if (store) begin
                            count <= count + 1'b1;
                        end else if (in_keep) begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            op_q <= op_dec;
                            acc  <= ident;
                            idx  <= '0;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (idx != count) begin
                        acc <= alu_out;
                        idx <= idx + 1'b1;
                    end else begin
                        res_data     <= acc;
                        res_count    <= count;
                        res_overflow <= overflow;
                        res_valid    <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // res_data/res_count/res_overflow keep their values after
                    // the handshake; only the frame bookkeeping clears.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        count     <= '0;
                        overflow  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_stream_reducer.sv
// Purpose : self-checking bench for array_stream_reducer with three instances
//           (RW=32 unsigned, RW=8 unsigned, RW=16 signed) fed the same stream.
// Latency : checks res_valid at count+1 edges after the closing-beat edge.
// Backpr. : exercises res_ready stalls with in_valid held high.
`timescale 1ns/1ps
module tb_array_stream_reducer;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_keep = 1'b0;
    logic          in_last = 1'b0;
    logic          res_ready = 1'b0;
    logic [7:0]    in_data = '0;
    logic [2:0]    op_sel = '0;

    logic          in_ready, res_valid, res_overflow;
    logic [31:0]   res_data;
    logic [CW-1:0] res_count;
    logic          w_in_ready, w_res_valid, w_res_overflow;
    logic [7:0]    w_res_data;
    logic [CW-1:0] w_res_count;
    logic          s_in_ready, s_res_valid, s_res_overflow;
    logic [15:0]   s_res_data;
    logic [CW-1:0] s_res_count;

    always #5 clk = ~clk;

    array_stream_reducer #(.DW(8), .RW(32), .DEPTH(DEPTH), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .op_sel(op_sel),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .res_overflow(res_overflow));

    array_stream_reducer #(.DW(8), .RW(8), .DEPTH(DEPTH), .SIGNED(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .op_sel(op_sel),
        .res_valid(w_res_valid), .res_ready(res_ready), .res_data(w_res_data),
        .res_count(w_res_count), .res_overflow(w_res_overflow));

    array_stream_reducer #(.DW(8), .RW(16), .DEPTH(DEPTH), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .op_sel(op_sel),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
        .res_count(s_res_count), .res_overflow(s_res_overflow));

    typedef struct {
        logic [63:0] d32;
        logic [63:0] d8;
        logic [63:0] d16s;
        int          cnt;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   frame[$];
    int   exp_lat = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference fold: elements beyond DEPTH are dropped, result taken mod 2^rw.
    function automatic logic [63:0] ref_reduce(input int op, input int rw, input bit sgn);
        logic [63:0] acc, e, mask;
        int          v;
        mask = (64'd1 << rw) - 64'd1;
        case (op)
            1:       acc = 64'd1;
            2:       acc = '1;
            default: acc = 64'd0;
        endcase
        for (int i = 0; i < frame.size() && i < DEPTH; i++) begin
            v = frame[i];
            e = {56'd0, v[7:0]};
            if (sgn && e[7]) e = e | 64'hFFFF_FFFF_FFFF_FF00;
            case (op)
                1:       acc = acc * e;
                2:       acc = acc & e;
                3:       acc = acc | e;
                4:       acc = acc ^ e;
                default: acc = acc + e;
            endcase
        end
        return acc & mask;
    endfunction

    task automatic drive_beat(input int d, input bit k, input bit l, input int op);
        int b;
        in_valid = 1'b1;
        in_data  = 8'(d);
        in_keep  = k;
        in_last  = l;
        // op_sel is scrambled on non-closing beats; only the closing one counts.
        op_sel   = l ? 3'(op) : 3'($urandom_range(0, 7));
        b = 0;
        while (!in_ready && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        if (!in_ready) chk("beat_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int op);
        exp_t x;
        int   n;
        n      = frame.size();
        x.d32  = ref_reduce(op, 32, 1'b0);
        x.d8   = ref_reduce(op, 8, 1'b0);
        x.d16s = ref_reduce(op, 16, 1'b1);
        x.cnt  = (n > DEPTH) ? DEPTH : n;
        x.ovf  = (n > DEPTH);
        exp_lat = x.cnt + 1;
        sb.push_back(x);
        if (n == 0) begin
            drive_beat(0, 1'b0, 1'b1, op);
        end else begin
            for (int i = 0; i < n; i++) drive_beat(frame[i], 1'b1, (i == n - 1), op);
        end
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int stall);
        int          lat, b;
        logic [63:0] xd;
        xd  = (sb.size() > 0) ? sb[0].d32 : 64'd0;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < stall; i++) begin
            // A closing beat offered during HOLD must not be taken.
            in_valid = 1'b1;
            in_keep  = 1'b1;
            in_last  = 1'b1;
            in_data  = 8'd99;
            @(posedge clk); #1;
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_res_data", 64'(res_data), xd);
        end
        in_valid  = 1'b0;
        in_keep   = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        b = 0;
        while (res_valid && b < 20) begin
            @(posedge clk); #1;
            b++;
        end
        res_ready = 1'b0;
        chk("hs_res_valid", 64'(res_valid), 64'd0);
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        chk("hs_res_data_kept", 64'(res_data), xd);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                x = sb.pop_front();
                chk("res_data", 64'(res_data), x.d32);
                chk("res_count", 64'(res_count), 64'(x.cnt));
                chk("res_overflow", 64'(res_overflow), 64'(x.ovf));
                chk("wrap_res_data", 64'(w_res_data), x.d8);
                chk("sgn_res_data", 64'(s_res_data), x.d16s);
                chk("lockstep_valid", 64'({w_res_valid, s_res_valid}), 64'd3);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_count", 64'(res_count), 64'd0);
        chk("rst_res_overflow", 64'(res_overflow), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Every operator over {1,2,3,4,5}: 15, 120, 0, 7, 1.
        for (int op = 0; op < 5; op++) begin
            frame = '{1, 2, 3, 4, 5};
            send_frame(op);
            collect(0);
        end

        frame = '{6, 7, 8};
        send_frame(0);
        collect(0);

        // Empty frames return the identity: 0, 1, all-ones.
        for (int op = 0; op < 3; op++) begin
            frame.delete();
            send_frame(op);
            collect(0);
        end

        // Ten ones into an eight-deep buffer, then a clean frame.
        frame.delete();
        for (int i = 0; i < 10; i++) frame.push_back(1);
        send_frame(0);
        collect(0);
        frame = '{9, 10, 11};
        send_frame(0);
        collect(0);

        // Wrap and sign extension.
        frame = '{200, 100};
        send_frame(0);
        collect(0);
        frame = '{255, 1};
        send_frame(0);
        collect(0);

        // Reserved op code folds as SUM.
        frame = '{2, 3};
        send_frame(7);
        collect(0);

        // Backpressure, then a frame showing no stall beat leaked in.
        frame = '{3, 4};
        send_frame(4);
        collect(5);
        frame = '{5};
        send_frame(3);
        collect(0);

        // Reset at idx=2 of a 5-element frame aborts it.
        frame = '{1, 2, 3, 4, 5};
        send_frame(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_res_data", 64'(res_data), 64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        frame = '{12, 13};
        send_frame(0);
        collect(0);

        if (sb.size() != 0) chk("sb_leftover", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
